// File: rtl/spi_send_arbiter.sv
// ============================================================================
// Module      : spi_send_arbiter
// Description : Round-robin, burst-granular arbiter sharing one SPI byte
//               sender between two byte-stream requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_send_arbiter #(
  parameter int BUSY_TIMEOUT = 1000,
  parameter int TO_W         = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_dc,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_dc,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       send_en,
  output logic       send_dc,
  output logic [7:0] send_data,
  input  logic       send_busy,
  output logic [1:0] grant,
  output logic       err_timeout
);

  localparam logic [2:0] c_ARB     = 3'd0;
  localparam logic [2:0] c_IDLE    = 3'd1;
  localparam logic [2:0] c_ISSUE   = 3'd2;
  localparam logic [2:0] c_WAIT_HI = 3'd3;
  localparam logic [2:0] c_WAIT_LO = 3'd4;

  // The ISSUE cycle is the first counted send_en cycle, so the last allowed one
  // is reached when the counter holds BUSY_TIMEOUT-1.
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  logic [2:0]      r_state, w_state_nxt;
  logic [1:0]      r_grant, w_grant_nxt;
  logic            r_last_served, w_last_served_nxt;
  logic            r_last, w_last_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            r_send_en, w_send_en_nxt;
  logic            r_send_dc, w_send_dc_nxt;
  logic [7:0]      r_send_data, w_send_data_nxt;
  logic [1:0]      r_ready, w_ready_nxt;
  logic            r_err, w_err_nxt;

  logic       w_own_valid;
  logic       w_own_dc;
  logic [7:0] w_own_data;
  logic       w_own_last;
  logic       w_issue;
  logic       w_to_hit;

  assign w_own_valid = r_grant[1] ? req1_valid : (r_grant[0] & req0_valid);
  assign w_own_dc    = r_grant[1] ? req1_dc    : req0_dc;
  assign w_own_data  = r_grant[1] ? req1_data  : req0_data;
  assign w_own_last  = r_grant[1] ? req1_last  : req0_last;
  assign w_issue     = w_own_valid && !send_busy;
  assign w_to_hit    = (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_ARB;
      r_grant       <= 2'b00;
      r_last_served <= 1'b1;
      r_last        <= 1'b0;
      r_to_cnt      <= '0;
      r_send_en     <= 1'b0;
      r_send_dc     <= 1'b0;
      r_send_data   <= 8'h00;
      r_ready       <= 2'b00;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last_served <= w_last_served_nxt;
      r_last        <= w_last_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_send_en     <= w_send_en_nxt;
      r_send_dc     <= w_send_dc_nxt;
      r_send_data   <= w_send_data_nxt;
      r_ready       <= w_ready_nxt;
      r_err         <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ARB:     if (req0_valid || req1_valid) w_state_nxt = c_IDLE;
      c_IDLE:    if (w_issue) w_state_nxt = c_ISSUE;
      c_ISSUE:   w_state_nxt = c_WAIT_HI;
      c_WAIT_HI: if (send_busy || w_to_hit) w_state_nxt = c_WAIT_LO;
      c_WAIT_LO: if (!send_busy) w_state_nxt = r_last ? c_ARB : c_IDLE;
      default:   w_state_nxt = c_ARB;
    endcase
  end

  always_comb begin
    w_grant_nxt       = r_grant;
    w_last_served_nxt = r_last_served;
    w_last_nxt        = r_last;
    w_to_cnt_nxt      = r_to_cnt;
    w_send_en_nxt     = r_send_en;
    w_send_dc_nxt     = r_send_dc;
    w_send_data_nxt   = r_send_data;
    w_ready_nxt       = 2'b00;
    w_err_nxt         = 1'b0;
    case (r_state)
      c_ARB: begin
        // On a tie the requester that was not served last wins.
        if (req0_valid && (!req1_valid || r_last_served)) w_grant_nxt = 2'b01;
        else if (req1_valid)                              w_grant_nxt = 2'b10;
      end
      c_IDLE: begin
        if (w_issue) begin
          w_send_en_nxt   = 1'b1;
          w_send_dc_nxt   = w_own_dc;
          w_send_data_nxt = w_own_data;
          w_last_nxt      = w_own_last;
          w_ready_nxt     = r_grant;
          w_to_cnt_nxt    = '0;
        end
      end
      c_ISSUE: begin
        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
      end
      c_WAIT_HI: begin
        if (send_busy) begin
          w_send_en_nxt = 1'b0;
        end else if (w_to_hit) begin
          w_send_en_nxt = 1'b0;
          w_err_nxt     = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      c_WAIT_LO: begin
        if (!send_busy && r_last) begin
          w_last_served_nxt = r_grant[1];
          w_grant_nxt       = 2'b00;
        end
      end
      default: begin
        w_grant_nxt   = 2'b00;
        w_send_en_nxt = 1'b0;
      end
    endcase
  end

  assign req0_ready  = r_ready[0];
  assign req1_ready  = r_ready[1];
  assign send_en     = r_send_en;
  assign send_dc     = r_send_dc;
  assign send_data   = r_send_data;
  assign grant       = r_grant;
  assign err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_send_arbiter.sv
// ============================================================================
// Module      : tb_spi_send_arbiter
// Description : Directed scoreboard bench for spi_send_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_send_arbiter;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_dc = 1'b0, req0_last = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_dc = 1'b0, req1_last = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       send_busy = 1'b0;
  logic       req0_ready, req1_ready, send_en, send_dc, err_timeout;
  logic [7:0] send_data;
  logic [1:0] grant;

  always #5 clk = ~clk;

  spi_send_arbiter #(.BUSY_TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_dc(req0_dc), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dc(req1_dc), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .send_en(send_en), .send_dc(send_dc), .send_data(send_data),
    .send_busy(send_busy), .grant(grant), .err_timeout(err_timeout)
  );

  int total = 0;
  int bad = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int owner_log[$];
  int rdy_cnt0, rdy_cnt1, err_cnt, en_run, last_en_len, busy_mode, sm_t;
  logic mon_prev_en, sm_prev;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_burst(input int id, input logic [7:0] b[$], input logic dc,
                             input logic final_b);
    int cnt;
    for (int i = 0; i < b.size(); i++) begin
      logic lst;
      lst = final_b && (i == b.size() - 1);
      if (id == 0) begin
        req0_valid = 1'b1; req0_dc = dc; req0_data = b[i]; req0_last = lst;
        q0.push_back({dc, b[i]});
      end else begin
        req1_valid = 1'b1; req1_dc = dc; req1_data = b[i]; req1_last = lst;
        q1.push_back({dc, b[i]});
      end
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!(id == 0 ? req0_ready : req1_ready) && cnt < 3000);
      chk($sformatf("ready_wait_r%0d", id), 32'(cnt < 3000), 1);
    end
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic wait_release(input string tag);
    int c;
    c = 0;
    while (!(grant == 2'b00 && !send_en && !send_busy) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(c < 1000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic int owner_code();
    int code;
    code = 0;
    foreach (owner_log[i]) code = code | (owner_log[i] << i);
    return code;
  endfunction

  initial begin
    fork
      // Monitor/scoreboard: one check per issued byte and per ready pulse.
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mon_prev_en = 1'b0;
          en_run = 0;
        end else begin
          if (send_en && !mon_prev_en) begin
            int o;
            logic [8:0] e;
            o = grant[1] ? 1 : 0;
            chk("issue_grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 1);
            owner_log.push_back(o);
            if (o == 0 && q0.size() > 0)      e = q0.pop_front();
            else if (o == 1 && q1.size() > 0) e = q1.pop_front();
            else                              e = 9'bx;
            chk($sformatf("issue_byte_r%0d", o), {23'd0, send_dc, send_data}, {23'd0, e});
            en_run = 0;
          end
          if (send_en) en_run++;
          if (!send_en && mon_prev_en) last_en_len = en_run;
          if (err_timeout) err_cnt++;
          if (req0_ready) rdy_cnt0++;
          if (req1_ready) rdy_cnt1++;
          if (req0_ready || req1_ready)
            chk("ready_owner", {30'd0, req1_ready, req0_ready}, {30'd0, grant});
          mon_prev_en = send_en;
        end
      end
      // Sender model: busy rises 2 cycles after send_en and holds 10 cycles.
      forever begin
        @(negedge clk);
        if (!rst_n || busy_mode != 0) begin
          sm_t = 0;
          send_busy = 1'b0;
        end else begin
          if (sm_t != 0)                 sm_t = (sm_t == 12) ? 0 : sm_t + 1;
          else if (send_en && !sm_prev)  sm_t = 1;
          send_busy = (sm_t >= 3);
        end
        sm_prev = send_en;
      end
    join_none

    busy_mode = 0; err_cnt = 0; rdy_cnt0 = 0; rdy_cnt1 = 0; last_en_len = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {12'd0, send_en, send_dc, send_data, req0_ready, req1_ready,
                          grant, err_timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", {12'd0, send_en, send_dc, send_data, req0_ready, req1_ready,
                               grant, err_timeout}, 0);

    // Three-byte command burst from req0.
    qa.delete(); qa.push_back(8'hB0); qa.push_back(8'h00); qa.push_back(8'h10);
    drive_burst(0, qa, 1'b0, 1'b1);
    wait_release("t1_release");
    chk("t1_issue_count", owner_log.size(), 3);
    chk("t1_owner_code", owner_code(), 0);
    chk("t1_ready0_pulses", rdy_cnt0, 3);
    chk("t1_ready1_pulses", rdy_cnt1, 0);
    chk("t1_en_len", last_en_len, 3);

    // Simultaneous requests after reset alternate req0, req1, req0, req1.
    do_reset();
    owner_log.delete();
    qa.delete(); qa.push_back(8'h01); qa.push_back(8'h02);
    qb.delete(); qb.push_back(8'h81); qb.push_back(8'h82);
    fork
      drive_burst(0, qa, 1'b0, 1'b1);
      drive_burst(1, qb, 1'b1, 1'b1);
    join
    wait_release("t2a_release");
    chk("t2a_order", owner_code(), 32'b1100);
    chk("t2a_count", owner_log.size(), 4);
    owner_log.delete();
    fork
      drive_burst(0, qa, 1'b1, 1'b1);
      drive_burst(1, qb, 1'b0, 1'b1);
    join
    wait_release("t2b_release");
    chk("t2b_order", owner_code(), 32'b1100);
    qa.delete(); qa.push_back(8'h3C);
    drive_burst(0, qa, 1'b0, 1'b1);
    wait_release("t2c_release");
    owner_log.delete();
    qa.delete(); qa.push_back(8'h44); qa.push_back(8'h45);
    fork
      drive_burst(0, qa, 1'b0, 1'b1);
      drive_burst(1, qb, 1'b1, 1'b1);
    join
    wait_release("t2d_release");
    chk("t2d_order_req1_first", owner_code(), 32'b0011);

    // req1 arrives during a 128-byte data burst and waits for its end.
    owner_log.delete();
    qa.delete();
    for (int i = 0; i < 128; i++) qa.push_back(8'(i * 3));
    qb.delete(); qb.push_back(8'hE1); qb.push_back(8'hE2);
    fork
      drive_burst(0, qa, 1'b1, 1'b1);
      begin
        repeat (50) @(negedge clk);
        drive_burst(1, qb, 1'b0, 1'b1);
      end
    join
    wait_release("t3_release");
    begin
      int first1;
      first1 = -1;
      foreach (owner_log[i]) if (owner_log[i] == 1 && first1 < 0) first1 = i;
      chk("t3_count", owner_log.size(), 130);
      chk("t3_first_req1_index", first1, 128);
    end

    // req0 stalls mid-burst; req1 stays blocked until req0 finishes.
    owner_log.delete();
    qa.delete(); qa.push_back(8'h20); qa.push_back(8'h21);
    drive_burst(0, qa, 1'b0, 1'b0);
    fork
      begin
        qb.delete(); qb.push_back(8'h90);
        drive_burst(1, qb, 1'b0, 1'b1);
      end
      begin
        repeat (30) @(negedge clk);
        chk("t4_grant_held", {30'd0, grant}, 2'b01);
        chk("t4_req1_blocked", owner_log.size(), 2);
        qa.delete(); qa.push_back(8'h22);
        drive_burst(0, qa, 1'b0, 1'b1);
      end
    join
    wait_release("t4_release");
    chk("t4_order", owner_code(), 32'b1000);

    // Sender never answers: send_en held TO cycles, then one err pulse.
    busy_mode = 1; err_cnt = 0;
    qa.delete(); qa.push_back(8'hC3);
    drive_burst(0, qa, 1'b0, 1'b1);
    wait_release("t5_release");
    chk("t5_en_len", last_en_len, TO);
    chk("t5_err_pulses", err_cnt, 1);

    // Asynchronous reset while waiting for busy.
    req0_valid = 1'b1; req0_dc = 1'b0; req0_data = 8'h5A; req0_last = 1'b0;
    q0.push_back({1'b0, 8'h5A});
    begin
      int c;
      c = 0;
      while (!send_en && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("t6_en_seen", 32'(c < 100), 1);
    end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", {27'd0, send_en, req0_ready, req1_ready, grant}, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy_mode = 0;
    q0.delete(); q1.delete();
    owner_log.delete();
    @(negedge clk);
    qb.delete(); qb.push_back(8'h77);
    drive_burst(1, qb, 1'b1, 1'b1);
    wait_release("t6_release");
    chk("t6_fresh_req1", owner_code(), 1);
    chk("t6_count", owner_log.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
